// File: rtl/go_pkg.sv
// Shared Go game types: point encoding, 9x9 board, pass move code and the
// turn sequencer state set.
package go_pkg;

  typedef logic [1:0] point_t;

  localparam point_t EMPTY = 2'b00;
  localparam point_t BLACK = 2'b01;
  localparam point_t WHITE = 2'b10;

  localparam int BOARD_DIM = 9;
  localparam logic [7:0] PASS_MOVE = 8'hFF;

  // board[row][col], each entry one point_t
  typedef point_t [BOARD_DIM-1:0][BOARD_DIM-1:0] board_t;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_CHECK       = 3'd1,
    ST_ISSUE       = 3'd2,
    ST_WAIT_UPD    = 3'd3,
    ST_COMMIT_MOVE = 3'd4,
    ST_COMMIT_PASS = 3'd5,
    ST_REJECT      = 3'd6,
    ST_GAME_OVER   = 3'd7
  } state_t;

endpackage

// File: rtl/turn_sequencer_move_screen.sv
// Combinational pre-screen of a {row,col} move against the committed board:
// flags a pass, an off-board coordinate, or an already occupied point.
module move_screen
  import go_pkg::*;
(
  input  logic [7:0] move,
  input  board_t     board,
  output logic       is_pass,
  output logic       off_board,
  output logic       occupied
);

  logic [3:0] row;
  logic [3:0] col;
  logic       hit;

  assign row = move[7:4];
  assign col = move[3:0];

  // Scan instead of direct indexing so off-board rows never address the array
  always_comb begin
    hit = 1'b0;
    for (int r = 0; r < BOARD_DIM; r++) begin
      for (int c = 0; c < BOARD_DIM; c++) begin
        if (row == 4'(r) && col == 4'(c) && board[r][c] != EMPTY) begin
          hit = 1'b1;
        end
      end
    end
  end

  assign is_pass   = (move == PASS_MOVE);
  assign off_board = !is_pass && ((row > 4'd8) || (col > 4'd8));
  assign occupied  = !is_pass && !off_board && hit;

endmodule

// File: rtl/turn_sequencer.sv
// Authoritative Go game state and move sequencing through board_updater.
// Optional per-turn move timer enabled by defining MOVE_TIMER_EN.
module turn_sequencer
  import go_pkg::*;
#(
  parameter int UPD_TIMEOUT = 64
`ifdef MOVE_TIMER_EN
  ,
  parameter logic [31:0] MOVE_TIME_CYCLES = 32'd1_950_000_000
`endif
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       new_game,
  input  logic       black_req,
  input  logic       white_req,
  input  logic [7:0] black_move,
  input  logic [7:0] white_move,
  output logic       black_ack,
  output logic       white_ack,
  output logic       black_nack,
  output logic       white_nack,
  output logic       upd_start,
  output logic [7:0] upd_move,
  output logic       upd_turn,
  output board_t     board_out,
  output board_t     ko_out,
  input  board_t     upd_next_board,
  input  logic       upd_valid,
  input  logic       upd_invalid,
  output logic       turn,
  output logic [1:0] pass_count,
  output logic [8:0] move_count,
  output logic       game_over
`ifdef MOVE_TIMER_EN
  ,
  output logic       timer_expired
`endif
);

  localparam int TW = $clog2(UPD_TIMEOUT) + 1;

  state_t        state;
  logic          mover;
  logic          guard;
  logic [TW-1:0] upd_cnt;
  logic          cur_req;
  logic [7:0]    cur_move;
  logic          is_pass;
  logic          off_board;
  logic          occupied;

`ifdef MOVE_TIMER_EN
  logic [31:0] move_tmr;
  logic        forced;
`endif

  function automatic logic [8:0] sat_moves(input logic [8:0] n);
    return (n == 9'd511) ? n : n + 9'd1;
  endfunction

  function automatic logic [1:0] sat_passes(input logic [1:0] n);
    return (n >= 2'd2) ? 2'd2 : n + 2'd1;
  endfunction

  assign cur_req   = turn ? white_req  : black_req;
  assign cur_move  = turn ? white_move : black_move;
  assign upd_start = (state == ST_ISSUE);
  assign upd_turn  = turn;
  assign game_over = (state == ST_GAME_OVER);

  move_screen u_screen (
    .move      (upd_move),
    .board     (board_out),
    .is_pass   (is_pass),
    .off_board (off_board),
    .occupied  (occupied)
  );

  always_ff @(posedge clk_in) begin
    black_ack  <= 1'b0;
    white_ack  <= 1'b0;
    black_nack <= 1'b0;
    white_nack <= 1'b0;
`ifdef MOVE_TIMER_EN
    timer_expired <= 1'b0;
`endif
    if (rst_in || new_game) begin
      state      <= ST_IDLE;
      board_out  <= '0;
      ko_out     <= '0;
      turn       <= 1'b0;
      pass_count <= 2'd0;
      move_count <= 9'd0;
      upd_move   <= 8'h00;
      mover      <= 1'b0;
      guard      <= 1'b0;
      upd_cnt    <= '0;
`ifdef MOVE_TIMER_EN
      forced     <= 1'b0;
`endif
    end else begin
      guard <= 1'b0;
      case (state)
        ST_IDLE: begin
`ifdef MOVE_TIMER_EN
          if (move_tmr == MOVE_TIME_CYCLES - 32'd1) begin
            mover    <= turn;
            upd_move <= PASS_MOVE;
            forced   <= 1'b1;
            state    <= ST_COMMIT_PASS;
          end else
`endif
          // guard keeps a requester that is just dropping req from re-entering
          if (!guard && cur_req) begin
            upd_move <= cur_move;
            mover    <= turn;
            state    <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (is_pass)                    state <= ST_COMMIT_PASS;
          else if (off_board || occupied) state <= ST_REJECT;
          else                            state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          upd_cnt <= '0;
          state   <= ST_WAIT_UPD;
        end
        ST_WAIT_UPD: begin
          if (upd_invalid || (upd_cnt == TW'(UPD_TIMEOUT - 1))) state <= ST_REJECT;
          else if (upd_valid)                                   state <= ST_COMMIT_MOVE;
          else                                                  upd_cnt <= upd_cnt + 1'b1;
        end
        ST_COMMIT_MOVE: begin
          ko_out     <= board_out;
          board_out  <= upd_next_board;
          turn       <= ~turn;
          pass_count <= 2'd0;
          move_count <= sat_moves(move_count);
          black_ack  <= ~mover;
          white_ack  <= mover;
          guard      <= 1'b1;
          state      <= ST_IDLE;
        end
        ST_COMMIT_PASS: begin
          ko_out     <= '0;
          turn       <= ~turn;
          pass_count <= sat_passes(pass_count);
          move_count <= sat_moves(move_count);
          black_ack  <= ~mover;
          white_ack  <= mover;
          guard      <= 1'b1;
`ifdef MOVE_TIMER_EN
          timer_expired <= forced;
          forced        <= 1'b0;
`endif
          state <= (sat_passes(pass_count) == 2'd2) ? ST_GAME_OVER : ST_IDLE;
        end
        ST_REJECT: begin
          black_nack <= ~mover;
          white_nack <= mover;
          guard      <= 1'b1;
          state      <= ST_IDLE;
        end
        ST_GAME_OVER: state <= ST_GAME_OVER;
        default:      state <= ST_IDLE;
      endcase
    end
  end

`ifdef MOVE_TIMER_EN
  // Turn clock only advances while waiting for the side to move
  always_ff @(posedge clk_in) begin
    if (rst_in || new_game) begin
      move_tmr <= 32'd0;
    end else if (state == ST_COMMIT_MOVE || state == ST_COMMIT_PASS) begin
      move_tmr <= 32'd0;
    end else if (state == ST_IDLE) begin
      move_tmr <= move_tmr + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed bench for turn_sequencer: placed moves, wrong-side requests,
// rejects (occupied, off-board, invalid, timeout), passes, game over, new game.
module tb_turn_sequencer;
  import go_pkg::*;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic       new_game = 1'b0;
  logic       black_req = 1'b0;
  logic       white_req = 1'b0;
  logic [7:0] black_move = 8'h00;
  logic [7:0] white_move = 8'h00;
  logic       black_ack, white_ack, black_nack, white_nack;
  logic       upd_start;
  logic [7:0] upd_move;
  logic       upd_turn;
  board_t     board_out, ko_out;
  board_t     upd_next_board = '0;
  logic       upd_valid = 1'b0;
  logic       upd_invalid = 1'b0;
  logic       turn;
  logic [1:0] pass_count;
  logic [8:0] move_count;
  logic       game_over;

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;
  int black_resp = 0;
  int white_resp = 0;

  board_t nb1, nb2, nb_bad, nb3;
  int     n;
  int     sc, bc, wc;

  turn_sequencer dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .new_game       (new_game),
    .black_req      (black_req),
    .white_req      (white_req),
    .black_move     (black_move),
    .white_move     (white_move),
    .black_ack      (black_ack),
    .white_ack      (white_ack),
    .black_nack     (black_nack),
    .white_nack     (white_nack),
    .upd_start      (upd_start),
    .upd_move       (upd_move),
    .upd_turn       (upd_turn),
    .board_out      (board_out),
    .ko_out         (ko_out),
    .upd_next_board (upd_next_board),
    .upd_valid      (upd_valid),
    .upd_invalid    (upd_invalid),
    .turn           (turn),
    .pass_count     (pass_count),
    .move_count     (move_count),
    .game_over      (game_over)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (upd_start) start_cnt++;
    if (black_ack || black_nack) black_resp++;
    if (white_ack || white_nack) white_resp++;
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic black_reject(input logic [7:0] mv, input string tag);
    sc = start_cnt;
    black_move = mv;
    black_req  = 1'b1;
    step();
    step();
    chk({tag, "_early"}, black_nack, 1'b0);
    step();
    chk({tag, "_nack"}, black_nack, 1'b1);
    chk({tag, "_nostart"}, start_cnt, sc);
    chk({tag, "_board"}, board_out, nb2);
    black_req = 1'b0;
    step();
    chk({tag, "_pulse"}, black_nack, 1'b0);
  endtask

  initial begin
    nb1 = '0; nb1[4][4] = BLACK;
    nb2 = nb1; nb2[0][0] = WHITE;
    nb_bad = nb2; nb_bad[2][2] = BLACK;
    nb3 = '0; nb3[8][8] = BLACK;

    step();
    step();
    rst_in = 1'b0;
    chk("rst_board", board_out, '0);
    chk("rst_ko", ko_out, '0);
    chk("rst_turn", turn, 1'b0);
    chk("rst_pass", pass_count, 2'd0);
    chk("rst_moves", move_count, 9'd0);
    chk("rst_over", game_over, 1'b0);
    chk("rst_updmove", upd_move, 8'h00);
    chk("rst_start", upd_start, 1'b0);

    // Black places at [4][4]
    black_move = 8'h44;
    black_req  = 1'b1;
    step();
    chk("m1_nostart", upd_start, 1'b0);
    step();
    chk("m1_start", upd_start, 1'b1);
    chk("m1_updmove", upd_move, 8'h44);
    chk("m1_updturn", upd_turn, 1'b0);
    upd_next_board = nb1;
    upd_valid = 1'b1;
    step();
    chk("m1_start1", upd_start, 1'b0);
    step();
    upd_valid = 1'b0;
    chk("m1_noack", black_ack, 1'b0);
    step();
    chk("m1_ack", black_ack, 1'b1);
    chk("m1_board", board_out, nb1);
    chk("m1_turn", turn, 1'b1);
    chk("m1_moves", move_count, 9'd1);
    chk("m1_ko", ko_out, '0);
    black_req = 1'b0;
    step();
    chk("m1_ackpulse", black_ack, 1'b0);

    // Black requests out of turn: ignored
    sc = start_cnt;
    bc = black_resp;
    black_move = 8'h00;
    black_req  = 1'b1;
    repeat (5) step();
    chk("oot_start", start_cnt, sc);
    chk("oot_resp", black_resp, bc);
    black_req = 1'b0;

    // White places at [0][0]
    white_move = 8'h00;
    white_req  = 1'b1;
    step();
    step();
    chk("m2_start", upd_start, 1'b1);
    chk("m2_updturn", upd_turn, 1'b1);
    upd_next_board = nb2;
    upd_valid = 1'b1;
    step();
    step();
    upd_valid = 1'b0;
    step();
    chk("m2_ack", white_ack, 1'b1);
    chk("m2_board", board_out, nb2);
    chk("m2_ko", ko_out, nb1);
    chk("m2_turn", turn, 1'b0);
    chk("m2_moves", move_count, 9'd2);
    white_req = 1'b0;
    step();

    black_reject(8'h44, "occ");
    black_reject(8'h9A, "row9");
    black_reject(8'h49, "col9");

    // Updater reports invalid (together with valid): invalid wins
    black_move = 8'h22;
    black_req  = 1'b1;
    step();
    step();
    upd_next_board = nb_bad;
    upd_valid   = 1'b1;
    upd_invalid = 1'b1;
    step();
    step();
    upd_valid   = 1'b0;
    upd_invalid = 1'b0;
    step();
    chk("inv_nack", black_nack, 1'b1);
    chk("inv_ack", black_ack, 1'b0);
    chk("inv_board", board_out, nb2);
    chk("inv_ko", ko_out, nb1);
    chk("inv_turn", turn, 1'b0);
    chk("inv_moves", move_count, 9'd2);
    black_req = 1'b0;
    step();

    // Updater silent: timeout reject
    black_move = 8'h22;
    black_req  = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!black_nack && n < 200);
    chk("tmo_latency", n, 68);
    chk("tmo_board", board_out, nb2);
    black_req = 1'b0;
    step();

    // Late updater result outside WAIT_UPD is ignored
    bc = black_resp;
    upd_next_board = nb_bad;
    upd_valid = 1'b1;
    step();
    step();
    upd_valid = 1'b0;
    chk("late_board", board_out, nb2);
    chk("late_resp", black_resp, bc);

    // Two passes end the game
    black_move = PASS_MOVE;
    black_req  = 1'b1;
    step();
    step();
    chk("p1_early", black_ack, 1'b0);
    step();
    chk("p1_ack", black_ack, 1'b1);
    chk("p1_pass", pass_count, 2'd1);
    chk("p1_turn", turn, 1'b1);
    chk("p1_moves", move_count, 9'd3);
    chk("p1_ko", ko_out, '0);
    chk("p1_board", board_out, nb2);
    chk("p1_over", game_over, 1'b0);
    black_req = 1'b0;
    step();
    white_move = PASS_MOVE;
    white_req  = 1'b1;
    step();
    step();
    step();
    chk("p2_ack", white_ack, 1'b1);
    chk("p2_pass", pass_count, 2'd2);
    chk("p2_over", game_over, 1'b1);
    chk("p2_moves", move_count, 9'd4);
    white_req = 1'b0;
    step();

    sc = start_cnt;
    bc = black_resp;
    black_move = 8'h33;
    black_req  = 1'b1;
    repeat (6) step();
    chk("go_start", start_cnt, sc);
    chk("go_resp", black_resp, bc);
    chk("go_hold", game_over, 1'b1);
    black_req = 1'b0;

    new_game = 1'b1;
    step();
    new_game = 1'b0;
    chk("ng_board", board_out, '0);
    chk("ng_ko", ko_out, '0);
    chk("ng_turn", turn, 1'b0);
    chk("ng_over", game_over, 1'b0);
    chk("ng_pass", pass_count, 2'd0);
    chk("ng_moves", move_count, 9'd0);

    // new_game while waiting on the updater; the late result is dropped
    bc = black_resp;
    black_move = 8'h55;
    black_req  = 1'b1;
    step();
    step();
    step();
    new_game  = 1'b1;
    black_req = 1'b0;
    step();
    new_game = 1'b0;
    upd_next_board = nb_bad;
    upd_valid = 1'b1;
    step();
    step();
    upd_valid = 1'b0;
    chk("fly_board", board_out, '0);
    chk("fly_resp", black_resp, bc);
    chk("fly_moves", move_count, 9'd0);

    // Corner move [8][8] after the restart
    black_move = 8'h88;
    black_req  = 1'b1;
    step();
    step();
    upd_next_board = nb3;
    upd_valid = 1'b1;
    step();
    step();
    upd_valid = 1'b0;
    step();
    chk("cor_ack", black_ack, 1'b1);
    chk("cor_board", board_out, nb3);
    chk("cor_turn", turn, 1'b1);
    black_req = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/turn_sequencer.md
Name: turn_sequencer

Overview:
Owns the authoritative game state: board, ko board, side to move, pass count and move count. Takes move requests from the black and white players and pre-screens each one. Legal-looking moves are sequenced through the board_updater instance (start pulse, then wait for valid/invalid), and the result is committed or rejected. Sits between the player input sources (local buttons, UART link) and board_updater; its board output feeds the display path.

Parameters:
UPD_TIMEOUT, 64, cycles to wait in WAIT_UPD for board_updater to respond before rejecting the move.
MOVE_TIME_CYCLES, 32'd1_950_000_000, per-turn time limit in cycles (only with MOVE_TIMER_EN).

Ports:
clk_in  in  1  system clock
rst_in  in  1  synchronous active-high reset
new_game  in  1  one-cycle pulse: clear the game
black_req / white_req  in  1  move request, level; held until ack or nack
black_move / white_move  in  8  {row[7:4], col[3:0]}; 8'hFF = pass
black_ack / white_ack  out  1  one-cycle pulse: move committed
black_nack / white_nack  out  1  one-cycle pulse: move rejected
upd_start  out  1  one-cycle start pulse to board_updater
upd_move  out  8  latched move
upd_turn  out  1  current turn (0 black, 1 white)
board_out  out  2x[8:0][8:0]  committed board; also drives updater board_bus
ko_out  out  2x[8:0][8:0]  ko board; drives updater ko_board
upd_next_board  in  2x[8:0][8:0]  updater result
upd_valid / upd_invalid  in  1  updater result pulses
turn  out  1  side to move
pass_count  out  2  consecutive passes, saturating at 2
move_count  out  9  committed moves including passes, saturating at 511
game_over  out  1  level

Behaviour:
- Point encoding: 00 empty, 01 black, 10 white, 11 illegal. Black moves first.
- Reset values: board and ko all 00; turn 0; pass_count 0; move_count 0; game_over 0; all pulse outputs 0; upd_move 8'h00; state IDLE.
- new_game is accepted in any state and has the same effect as reset, except that it never drives ack/nack. An in-flight updater result arriving afterwards is ignored.
- States and transitions:
  - IDLE: sample only the requester whose colour equals turn. The other requester is never acknowledged and waits. If the current requester's req=1, latch its move into upd_move and go to CHECK.
  - CHECK:
    - move==8'hFF: go to COMMIT_PASS.
    - row>8 or col>8: go to REJECT.
    - board_out[row][col]!=00: go to REJECT (board_updater does not check occupancy).
    - otherwise: go to ISSUE.
  - ISSUE: upd_start=1 for exactly one cycle; clear the timeout counter; go to WAIT_UPD.
  - WAIT_UPD:
    - upd_valid: go to COMMIT_MOVE.
    - upd_invalid, or timeout counter reaching UPD_TIMEOUT-1: go to REJECT.
    - If upd_valid and upd_invalid arrive together, invalid wins.
  - COMMIT_MOVE: ko <= board_out; board <= upd_next_board; turn flips; pass_count <= 0; move_count++; ack the mover; go to IDLE.
  - COMMIT_PASS: ko <= all-empty; board unchanged; turn flips; pass_count++; move_count++; ack the mover. If pass_count becomes 2, go to GAME_OVER, otherwise go to IDLE.
  - REJECT: nack the mover; board, ko, turn and counts are unchanged; go to IDLE.
  - GAME_OVER: game_over=1; all requests are ignored with no ack or nack; exit only via new_game or reset.
- Handshake:
  - ack/nack goes to the requester latched in IDLE, even if it dropped req mid-operation.
  - After an ack/nack, IDLE ignores req for one cycle (a guard bit), so a requester that drops req on seeing the response is not re-sampled.
- Latency: an occupied or off-board move is nacked 3 cycles after req is sampled. A pass is acked in 3 cycles. A placed move takes updater latency plus 4 cycles.
- board_out and ko_out are stable from ISSUE through WAIT_UPD; they change only in the COMMIT states.
- upd_valid/upd_invalid are ignored outside WAIT_UPD.

Optional Feature:
MOVE_TIMER_EN:
- Defined: a per-turn counter runs in IDLE and clears on every commit and on new_game. When it reaches MOVE_TIME_CYCLES-1 in IDLE, the sequencer performs a forced pass via COMMIT_PASS, acking the current-turn player. Adds output timer_expired, a one-cycle pulse in that case.
- Not defined: no counter and no timer_expired port; turns are unlimited.

Decomposition:
Shared package go_pkg holds:
- typedef point_t (2 bits) and constants EMPTY=2'b00, BLACK=2'b01, WHITE=2'b10
- typedef board_t for the 9x9 array
- PASS_MOVE=8'hFF, BOARD_DIM=9
- the state enum
One natural sub-module, move_screen: combinational decode of move plus board into is_pass, off_board and occupied, used by CHECK.

Test Plan:
1. Reset, then black_req with move 8'h44 and updater responding valid with 01 at [4][4] -> black_ack pulse; board_out[4][4]=01; turn=1; move_count=1; ko_out all-empty.
2. Turn=1 (white to move), black_req=1 held with 8'h00 -> no black ack/nack and upd_start stays 0. white_req with 8'h00 -> sequenced normally.
3. Move 8'h44 onto the occupied point [4][4] -> nack 3 cycles after req; upd_start never asserts; state unchanged.
4. Move 8'h9A (row 9) -> nack. Updater returns upd_invalid -> nack with board unchanged. Updater silent for UPD_TIMEOUT cycles -> nack and return to IDLE.
5. Black pass, then white pass -> acks, pass_count=2, game_over=1; further reqs ignored. new_game -> board empty, turn=0, game_over=0.
6. (MOVE_TIMER_EN) MOVE_TIME_CYCLES=100, no req -> timer_expired and ack to current player at cycle 100; turn flips; pass_count=1.
